ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Shares one single-cycle-read word RAM (bus_if slave: raddr/waddr/ren/wen/wdata/bytemask/rdata)
//  between two requesters: port 0 = instruction fetch, port 1 = load/store unit.
//  Arbitrates per cycle round-robin, drives the RAM bus_if master side, and returns read data.
//  Read data comes back on the granted port one cycle later. Sits between core and on-chip RAM.
// PARAMETERS
//  ADDR_W  32  byte address width on requester ports and RAM bus (word index = addr[.. :2])
//  DATA_W  32  data width; bytemask width = DATA_W/8
// PORTS
//  clk            in   1        clock; all state on rising edge
//  rst_n          in   1        asynchronous, active-low reset
//  req_valid[i]   in   1        requester i (i=0,1) presents a transaction
//  req_we[i]      in   1        1 = write, 0 = read
//  req_addr[i]    in   ADDR_W   byte address (word aligned; addr[1:0] ignored)
//  req_wdata[i]   in   DATA_W   write data
//  req_mask[i]    in   DATA_W/8 byte enables for writes
//  req_ready[i]   out  1        transaction accepted this cycle (valid & ready = handshake)
//  rsp_valid[i]   out  1        read data valid on rsp_rdata (one cycle after read handshake)
//  rsp_rdata      out  DATA_W   shared read return data (= mem.rdata)
//  mem            bus_if.master -  RAM-side bus
// BEHAVIOUR
//  - Reset: last_gnt <= 1 (port 0 wins first tie), rsp_valid <= 0, rd_owner <= 0. ren/wen/req_ready
//    are combinational and 0 while no request is present.
//  - Grant: one request only -> that port. Both -> port != last_gnt; last_gnt updates on every handshake.
//  - req_ready[i] is combinational from req_valid/last_gnt; a requester must hold its request
//    stable until ready. Ungranted port sees ready=0; no state is lost.
//  - Granted read: mem.ren=1, mem.raddr=req_addr; next cycle rsp_valid[owner]=1, rsp_rdata=mem.rdata.
//    Granted write: mem.wen=1, waddr/wdata/bytemask driven; completes at the edge; no response.
//  - Latency: read = 1 cycle handshake->rsp_valid; back-to-back reads by one port at full rate.
//  - rsp_valid is a 1-cycle pulse; no backpressure on responses (requester must take it).
//  - mem.rdata holds between reads (RAM only updates on ren); rsp_rdata is ignored when no rsp_valid.
//  - Reset mid-read: pending rsp_valid dropped; the in-flight read is lost, never reissued.
//  - No state machine beyond last_gnt and the rd_owner/rsp_valid pipeline register.
// CONFIGURATION
//  - RAM_ARB_DUAL_ISSUE_EN defined: if one port reads and the other writes in the same cycle,
//    both get ready=1; read on raddr, write on waddr simultaneously; last_gnt unchanged.
//    Same word address: the read returns the OLD data (RAM is read-before-write).
//    Two reads or two writes still arbitrate round-robin.
//  - Not defined: strictly one transaction per cycle; the above case arbitrates round-robin.
// STRUCTURE
//  - ram_arb_pkg: NUM_PORTS=2, typedef enum logic {PORT_IF=0, PORT_LSU=1} port_e,
//    typedef struct packed {we, addr, wdata, mask} ram_req_t.
//  - Sub-module rr_arb2: 2-input round-robin grant (req[1:0], advance, gnt[1:0], registered last_gnt).
// TESTING
//  1 Reset: rst_n=0 with both valid -> all ready=0, rsp_valid=0; first cycle after release both
//    read -> port0 ready, port1 ready next cycle.
//  2 Port0 read 0x10 (mem[4]=0xDEADBEEF) -> ready0 same cycle; next cycle rsp_valid[0]=1,
//    rsp_rdata=0xDEADBEEF; rsp_valid[1]=0.
//  3 Both ports issue 4 reads continuously -> grants alternate 0,1,0,1,...; each rsp_valid routed to
//    the issuing port.
//  4 Port1 write 0x20 data 0x11223344 mask 4'b0101, then read 0x20 (old 0xAABBCCDD)
//    -> rdata 0xAA22CC44.
//  5 Port0 read 0x20 + port1 write 0x20 same cycle: with RAM_ARB_DUAL_ISSUE_EN both ready, read
//    returns old word; without it only the round-robin winner is ready, loser completes next cycle.
//  6 Assert rst_n=0 the cycle after a read handshake -> rsp_valid stays 0; post-reset state as in 1.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and constants for the two-port RAM arbiter.
//   NUM_PORTS   : number of requesters (instruction fetch, load/store)
//   port_e      : requester identifier
//   ram_req_t   : one requester's transaction fields bundled together
//   port_onehot : converts a port id into a one-hot port vector
// ----------------------------------------------------------------------------
package ram_arb_pkg;

   localparam int NUM_PORTS  = 2;
   localparam int RAM_ADDR_W = 32;
   localparam int RAM_DATA_W = 32;
   localparam int RAM_MASK_W = RAM_DATA_W / 8;

   typedef enum logic {
      PORT_IF  = 1'b0,
      PORT_LSU = 1'b1
   } port_e;

   typedef struct packed {
      logic                  we;
      logic [RAM_ADDR_W-1:0] addr;
      logic [RAM_DATA_W-1:0] wdata;
      logic [RAM_MASK_W-1:0] mask;
   } ram_req_t;

   function automatic logic [NUM_PORTS-1:0] port_onehot(input port_e p);
      return (p == PORT_LSU) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/bus_if.sv
// ----------------------------------------------------------------------------
// bus_if
// Single-cycle-read word RAM bus. Addresses are byte addresses; the RAM uses
// addr[..:2] as the word index. rdata updates only on a cycle with ren=1 and
// holds otherwise. A read and a write to the same word in one cycle return
// the old contents (read-before-write).
//   raddr/ren          : read address / read strobe
//   waddr/wen          : write address / write strobe
//   wdata/bytemask     : write data / byte enables
//   rdata              : read data, valid the cycle after ren
// ----------------------------------------------------------------------------
interface bus_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   raddr;
   logic [ADDR_W-1:0]   waddr;
   logic                ren;
   logic                wen;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] bytemask;
   logic [DATA_W-1:0]   rdata;

   modport master (
      output raddr, waddr, ren, wen, wdata, bytemask,
      input  rdata
   );

   modport slave (
      input  raddr, waddr, ren, wen, wdata, bytemask,
      output rdata
   );
endinterface

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. A single requester always wins; when both
// request, the port that did not win last time is granted. The remembered
// winner updates only when the caller signals that the grant was consumed.
//   clk     : clock
//   rst_n   : asynchronous active-low reset (last winner = port 1, so port 0
//             wins the first tie)
//   req     : request vector
//   advance : grant was used this cycle; remember the winner
//   gnt     : one-hot grant (combinational)
// ----------------------------------------------------------------------------
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   port_e last_gnt_reg;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_gnt_reg == PORT_LSU) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_reg <= PORT_LSU;
      end else if (advance) begin
         last_gnt_reg <= gnt[1] ? PORT_LSU : PORT_IF;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
// Shares one single-cycle-read RAM between instruction fetch (port 0) and the
// load/store unit (port 1). Per-cycle round-robin grant; read data returns on
// the shared rsp_rdata one cycle after the read handshake, flagged by
// rsp_valid on the issuing port.
//
// Optional feature (macro RAM_ARB_DUAL_ISSUE_EN): when one port reads and the
// other writes in the same cycle, both are accepted together and the
// round-robin state is left untouched.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   req_valid[i]     : requester i presents a transaction
//   req_we[i]        : 1 = write, 0 = read
//   req_addr[i]      : byte address (addr[1:0] ignored by the RAM)
//   req_wdata[i]     : write data
//   req_mask[i]      : write byte enables
//   req_ready[i]     : transaction accepted this cycle (combinational)
//   rsp_valid[i]     : one-cycle pulse, read data for port i on rsp_rdata
//   rsp_rdata        : shared read return data (RAM rdata)
//   mem              : RAM bus, master side
// ----------------------------------------------------------------------------
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
)
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [1:0]                    req_valid,
   input  logic [1:0]                    req_we,
   input  logic [1:0][ADDR_W-1:0]        req_addr,
   input  logic [1:0][DATA_W-1:0]        req_wdata,
   input  logic [1:0][DATA_W/8-1:0]      req_mask,
   output logic [1:0]                    req_ready,
   output logic [1:0]                    rsp_valid,
   output logic [DATA_W-1:0]             rsp_rdata,
   bus_if.master                         mem
);

   ram_req_t   req [NUM_PORTS];
   logic [1:0] live_valid;
   logic [1:0] gnt;
   logic       arb_advance;
   logic       dual_issue;
   port_e      rd_port;
   port_e      wr_port;
   logic       do_read;
   logic       do_write;

   logic       rsp_valid_reg;
   port_e      rd_owner_reg;

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_req
         assign req[gi] = '{we:    req_we[gi],
                            addr:  req_addr[gi],
                            wdata: req_wdata[gi],
                            mask:  req_mask[gi]};
      end
   endgenerate

   // Nothing is accepted while reset is held, even though the grant path is
   // purely combinational.
   assign live_valid = req_valid & {2{rst_n}};

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (live_valid),
      .advance (arb_advance),
      .gnt     (gnt)
   );

`ifdef RAM_ARB_DUAL_ISSUE_EN
   assign dual_issue = (live_valid == 2'b11) && (req_we[0] != req_we[1]);
`else
   assign dual_issue = 1'b0;
`endif

   always_comb begin
      req_ready   = dual_issue ? 2'b11 : gnt;
      // A dual-issue cycle serves both ports, so fairness state stays put.
      arb_advance = (|gnt) && !dual_issue;
      if (dual_issue) begin
         rd_port = req_we[0] ? PORT_LSU : PORT_IF;
         wr_port = req_we[0] ? PORT_IF  : PORT_LSU;
      end else begin
         rd_port = gnt[1] ? PORT_LSU : PORT_IF;
         wr_port = rd_port;
      end
      do_read  = |(req_ready & ~req_we);
      do_write = |(req_ready & req_we);
   end

   always_comb begin
      mem.ren      = do_read;
      mem.raddr    = req[rd_port].addr;
      mem.wen      = do_write;
      mem.waddr    = req[wr_port].addr;
      mem.wdata    = req[wr_port].wdata;
      mem.bytemask = do_write ? req[wr_port].mask : '0;
   end

   // Response pipeline: remembers which port issued the read so the returned
   // word is flagged on the right port one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_reg <= 1'b0;
         rd_owner_reg  <= PORT_IF;
      end else begin
         rsp_valid_reg <= do_read;
         if (do_read) begin
            rd_owner_reg <= rd_port;
         end
      end
   end

   assign rsp_valid = rsp_valid_reg ? port_onehot(rd_owner_reg) : 2'b00;
   assign rsp_rdata = mem.rdata;

endmodule
